sync_pulse_gen_multi: RTL and testbench
=======================================

// Module: sync_pulse_gen_multi
// PURPOSE
//  Register-programmable multi-channel periodic sync pulse generator with an AXI4-Lite slave.
//  Each channel emits a periodic pulse of programmable period, width and phase offset.
//  Channels share one timebase restart, so channels enabled together stay phase-aligned.
//  Sits in the PL clock domain next to the radio datapath and drives frame/slot sync strobes.
// PARAMETERS
//  NUM_CH      4   number of pulse channels, 1..8
//  CNT_W       32  width of period/width/offset counters, 8..32
//  ADDR_W      8   AXI4-Lite byte address width; must cover 0x10+NUM_CH*0x10
// PORTS
//  clk            in   1       single clock for AXI and generator
//  rst            in   1       synchronous, active-high reset
//  s_axi_awaddr   in   ADDR_W  write address
//  s_axi_awvalid  in   1       / s_axi_awready out 1
//  s_axi_wdata    in   32      write data; s_axi_wstrb in 4 byte enables
//  s_axi_wvalid   in   1       / s_axi_wready out 1
//  s_axi_bresp    out  2       always 2'b00; s_axi_bvalid out 1 / s_axi_bready in 1
//  s_axi_araddr   in   ADDR_W  read address; s_axi_arvalid in 1 / s_axi_arready out 1
//  s_axi_rdata    out  32      read data; s_axi_rresp out 2 (always 2'b00)
//  s_axi_rvalid   out  1       / s_axi_rready in 1
//  sync_o         out  NUM_CH  registered pulse outputs, one per channel
//  ext_trig_i     in   1       external restart strobe (only with SPG_EXT_TRIG_EN)
// BEHAVIOUR
//  Reset: all AXI ready/valid low, rdata 0, sync_o 0, all registers 0, all counters 0.
//  AXI write: accept only when awvalid&wvalid both high and bvalid low.
//   awready=wready=1 for exactly that cycle; bvalid next cycle, held until bready.
//   wstrb applied per byte. Writes to read-only or unmapped addresses are dropped, still OKAY.
//  AXI read: arready=1 when rvalid low; rdata/rvalid next cycle, held until rready.
//   Unmapped reads return 0. Simultaneous read and write are both serviced independently.
//  Map: 0x00 CTRL  [0] global enable, [1] resync (self-clearing), [8+k] channel k enable
//       0x04 STATUS [k] channel k running (RO)
//       0x10+k*0x10: +0 PERIOD, +4 WIDTH, +8 OFFSET (shadowed RW), +C PULSE_CNT (RO, W1 any = clear)
//   Fields wider than CNT_W: upper bits read 0.
//  Channel k running = global enable & channel enable & PERIOD!=0.
//  Counter cnt: 0..PERIOD-1, wraps to 0; held at 0 while not running.
//  Restart: resync write, or rising edge of running, zeroes cnt the following cycle.
//  sync_o[k] (registered, 1-cycle latency from cnt) = running & (cnt>=OFFSET) & (cnt<OFFSET+WIDTH).
//   Compare in CNT_W+1 bits. No wrap past period end: OFFSET+WIDTH>PERIOD truncates at PERIOD-1.
//   WIDTH=0 or OFFSET>=PERIOD: sync_o stays 0.
//  Shadowing: AXI writes land in shadow regs. Active copies update when cnt==PERIOD-1 (wrap)
//   or while not running. Reads return shadow values.
//  PULSE_CNT increments (saturating 32 bit) on each sync_o rising edge.
//   Clear and increment in the same cycle: the clear wins.
//  Disable mid-pulse: sync_o drops the cycle after running falls. rst mid-pulse: outputs to reset values.
// CONFIGURATION
//  SPG_EXT_TRIG_EN defined: port ext_trig_i exists; CTRL[2] arms trigger.
//   While armed, channels hold cnt=0, sync_o=0. First ext_trig_i high clears arm and starts all
//   enabled channels at cnt=0 the next cycle. STATUS[31] = armed.
//  SPG_EXT_TRIG_EN undefined: no ext_trig_i port; CTRL[2] and STATUS[31] read 0.
// TESTING
//  Reset then read all registers -> all 0, sync_o=0, bresp/rresp OKAY.
//  ch0 PERIOD=10, WIDTH=3, OFFSET=2, CTRL=0x101 -> sync_o[0] high 3 cycles, every 10 cycles,
//   first rising edge 3 cycles after the enable write's bvalid.
//  Write PERIOD=20 mid-period -> current period completes at 10, next at 20; shadow reads 20 immediately.
//  ch0/ch1 same PERIOD=8, OFFSET 0/4, WIDTH=4, enable together -> complementary outputs, never both high.
//  WIDTH=12, PERIOD=10, OFFSET=5 -> high cycles 5..9 only; PERIOD=0 -> STATUS bit 0, sync_o 0.
//  SPG_EXT_TRIG_EN: arm, wait 50 cycles (sync_o 0), pulse ext_trig_i -> all channels restart at cnt 0,
//   STATUS[31] clears.

Source files
------------

// File: rtl/sync_pulse_gen_multi.sv
// Multi-channel periodic sync pulse generator with an AXI4-Lite register slave.
// Define SPG_EXT_TRIG_EN to add the ext_trig_i port and the armed-restart feature.
module sync_pulse_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [NUM_CH-1:0] sync_o
`ifdef SPG_EXT_TRIG_EN
  ,
  input  logic              ext_trig_i
`endif
);

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  logic              bvalid_reg;
  logic              rvalid_reg;
  logic [31:0]       rdata_reg;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-3:0] wr_word;
  logic [ADDR_W-3:0] rd_word;
  logic [ADDR_W-5:0] wr_blk;
  logic [ADDR_W-5:0] rd_blk;
  logic [1:0]        wr_sub;
  logic [1:0]        rd_sub;
  logic [31:0]       wstrb_mask;

  // Write is taken only when both channels are presented and no response is pending.
  assign wr_en         = s_axi_awvalid & s_axi_wvalid & ~bvalid_reg & ~rst;
  assign s_axi_awready = wr_en;
  assign s_axi_wready  = wr_en;
  assign s_axi_arready = ~rvalid_reg & ~rst;
  assign rd_en         = s_axi_arvalid & s_axi_arready;
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = 2'b00;

  assign wr_word    = s_axi_awaddr[ADDR_W-1:2];
  assign rd_word    = s_axi_araddr[ADDR_W-1:2];
  assign wr_blk     = s_axi_awaddr[ADDR_W-1:4];
  assign rd_blk     = s_axi_araddr[ADDR_W-1:4];
  assign wr_sub     = s_axi_awaddr[3:2];
  assign rd_sub     = s_axi_araddr[3:2];
  assign wstrb_mask = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                       {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};

  logic              ge_reg;
  logic [NUM_CH-1:0] ch_en_reg;
  logic              armed;
  logic [31:0]       ctrl_rd;
  logic [31:0]       status_rd;
  logic [31:0]       ctrl_wr_val;
  logic              wr_ctrl;
  logic              resync;
  logic [NUM_CH-1:0] running;

  always_comb begin
    ctrl_rd               = '0;
    ctrl_rd[0]            = ge_reg;
    ctrl_rd[2]            = armed;
    ctrl_rd[8 +: NUM_CH]  = ch_en_reg;
    status_rd             = '0;
    status_rd[NUM_CH-1:0] = running;
    status_rd[31]         = armed;
  end

  assign wr_ctrl     = wr_en & (wr_word == '0);
  assign ctrl_wr_val = apply_strb(ctrl_rd, s_axi_wdata, s_axi_wstrb);
  // Resync is a strobe: it acts on the write cycle and is never stored.
  assign resync      = wr_ctrl & ctrl_wr_val[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ge_reg    <= 1'b0;
      ch_en_reg <= '0;
    end else if (wr_ctrl) begin
      ge_reg    <= ctrl_wr_val[0];
      ch_en_reg <= ctrl_wr_val[8 +: NUM_CH];
    end
  end

`ifdef SPG_EXT_TRIG_EN
  logic arm_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_reg <= 1'b0;
    end else if (wr_ctrl) begin
      arm_reg <= ctrl_wr_val[2];
    end else if (ext_trig_i) begin
      arm_reg <= 1'b0;
    end
  end
  assign armed = arm_reg;
`else
  assign armed = 1'b0;
`endif

  logic [31:0] period_rd [NUM_CH];
  logic [31:0] width_rd  [NUM_CH];
  logic [31:0] offset_rd [NUM_CH];
  logic [31:0] pcnt_rd   [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] period_reg;
      logic [CNT_W-1:0] width_reg;
      logic [CNT_W-1:0] offset_reg;
      logic [CNT_W-1:0] period_act_reg;
      logic [CNT_W-1:0] width_act_reg;
      logic [CNT_W-1:0] offset_act_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic [31:0]      pulse_cnt_reg;
      logic             sync_reg;
      logic             sync_next;
      logic             gen_en;
      logic             wrap;
      logic             wr_sel;
      logic             pcnt_clr;
      logic [CNT_W:0]   win_end;

      assign running[gi] = ge_reg & ch_en_reg[gi] & (period_reg != '0);
      assign gen_en      = running[gi] & ~armed;
      assign wrap        = (period_act_reg == '0) ||
                           (cnt_reg >= period_act_reg - CNT_W'(1));
      // Window end is one bit wider so OFFSET+WIDTH cannot overflow.
      assign win_end     = {1'b0, offset_act_reg} + {1'b0, width_act_reg};
      assign sync_next   = gen_en & (cnt_reg >= offset_act_reg) &
                           ({1'b0, cnt_reg} < win_end);
      assign wr_sel      = wr_en & (wr_blk == (ADDR_W-4)'(gi + 1));
      assign pcnt_clr    = wr_sel & (wr_sub == 2'd3) &
                           (|(s_axi_wdata & wstrb_mask));

      always_ff @(posedge clk) begin
        if (rst) begin
          period_reg     <= '0;
          width_reg      <= '0;
          offset_reg     <= '0;
          period_act_reg <= '0;
          width_act_reg  <= '0;
          offset_act_reg <= '0;
          cnt_reg        <= '0;
          pulse_cnt_reg  <= '0;
          sync_reg       <= 1'b0;
        end else begin
          if (wr_sel) begin
            case (wr_sub)
              2'd0: period_reg <= CNT_W'(apply_strb(32'(period_reg), s_axi_wdata, s_axi_wstrb));
              2'd1: width_reg  <= CNT_W'(apply_strb(32'(width_reg), s_axi_wdata, s_axi_wstrb));
              2'd2: offset_reg <= CNT_W'(apply_strb(32'(offset_reg), s_axi_wdata, s_axi_wstrb));
              default: ;
            endcase
          end

          if (!gen_en || resync || wrap) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end

          // Shadow-to-active transfer only at a period boundary or while idle.
          if (!gen_en || wrap) begin
            period_act_reg <= period_reg;
            width_act_reg  <= width_reg;
            offset_act_reg <= offset_reg;
          end

          sync_reg <= sync_next;

          if (pcnt_clr) begin
            pulse_cnt_reg <= '0;
          end else if (sync_next && !sync_reg && (pulse_cnt_reg != '1)) begin
            pulse_cnt_reg <= pulse_cnt_reg + 32'd1;
          end
        end
      end

      assign sync_o[gi]    = sync_reg;
      assign period_rd[gi] = 32'(period_reg);
      assign width_rd[gi]  = 32'(width_reg);
      assign offset_rd[gi] = 32'(offset_reg);
      assign pcnt_rd[gi]   = pulse_cnt_reg;
    end
  endgenerate

  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (rd_word == '0) begin
      rd_val = ctrl_rd;
    end else if (rd_word == (ADDR_W-2)'(1)) begin
      rd_val = status_rd;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (rd_blk == (ADDR_W-4)'(k + 1)) begin
          case (rd_sub)
            2'd0:    rd_val = period_rd[k];
            2'd1:    rd_val = width_rd[k];
            2'd2:    rd_val = offset_rd[k];
            default: rd_val = pcnt_rd[k];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_reg <= 1'b0;
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      if (wr_en) begin
        bvalid_reg <= 1'b1;
      end else if (s_axi_bready) begin
        bvalid_reg <= 1'b0;
      end
      if (rd_en) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_val;
      end else if (s_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], ctrl_wr_val};

endmodule

// File: tb/tb_sync_pulse_gen_multi.sv
// Directed self-checking bench for sync_pulse_gen_multi (AXI register access and pulse timing).
module tb_sync_pulse_gen_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] s_axi_awaddr = '0;
  logic              s_axi_awvalid = 1'b0;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata = '0;
  logic [3:0]        s_axi_wstrb = '0;
  logic              s_axi_wvalid = 1'b0;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready = 1'b0;
  logic [ADDR_W-1:0] s_axi_araddr = '0;
  logic              s_axi_arvalid = 1'b0;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready = 1'b0;
  logic [NUM_CH-1:0] sync_o;
  logic              ext_trig = 1'b0;

  sync_pulse_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .sync_o        (sync_o)
`ifdef SPG_EXT_TRIG_EN
    ,
    .ext_trig_i    (ext_trig)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_q[$];
  logic prev0 = 1'b0;

  // Cycle stamp of every rising edge on sync_o[0].
  always @(negedge clk) begin
    if (sync_o[0] && !prev0) rise_q.push_back(cyc);
    prev0 = sync_o[0];
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (s_axi_awready && s_axi_wready) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk($sformatf("aw_ready@%02h", addr), 32'(ok), 32'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk($sformatf("bvalid@%02h", addr), 32'(s_axi_bvalid), 32'd1);
    chk($sformatf("bresp@%02h", addr), 32'(s_axi_bresp), 32'd0);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    $display("write addr=0x%02h data=0x%08h strb=%b", addr, data, strb);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (s_axi_arready) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk($sformatf("ar_ready@%02h", addr), 32'(ok), 32'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    chk($sformatf("rvalid@%02h", addr), 32'(s_axi_rvalid), 32'd1);
    chk($sformatf("rresp@%02h", addr), 32'(s_axi_rresp), 32'd0);
    data = s_axi_rdata;
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    $display("read  addr=0x%02h data=0x%08h", addr, data);
  endtask

  task automatic read_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    chk(tag, d, exp);
  endtask

  // Cycle k counts posedges after the starting edge; the pulse is high when the
  // counter value one cycle earlier, (k-1) mod period, lies in [lo, hi).
  task automatic expect_window(input string tag, input int n, input int period,
                               input int lo, input int hi, input int ch);
    logic exp;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      exp = (((k - 1) % period) >= lo) && (((k - 1) % period) < hi);
      chk($sformatf("%s[%0d]", tag, k), 32'(sync_o[ch]), 32'(exp));
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sync_o", 32'(sync_o), 32'd0);
    chk("rst_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
    chk("rst_valid", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int highs;
    logic exp0;

    // Reset, then every register reads zero.
    do_reset();
    read_chk("rst_ctrl", 8'h00, 32'd0);
    read_chk("rst_status", 8'h04, 32'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      for (int r = 0; r < 4; r++) begin
        read_chk($sformatf("rst_ch%0d_r%0d", c, r), 8'(16 + c*16 + r*4), 32'd0);
      end
    end

    // Basic channel: period 10, width 3, offset 2.
    axi_write(8'h10, 32'd10, 4'hF);
    axi_write(8'h14, 32'd3, 4'hF);
    axi_write(8'h18, 32'd2, 4'hF);
    axi_write(8'h00, 32'h101, 4'hF);
    expect_window("basic", 25, 10, 2, 5, 0);

    // Period change mid-period takes effect at the next wrap.
    rise_q.delete();
    for (int i = 0; i < 30 && rise_q.size() == 0; i++) @(negedge clk);
    chk("rise_seen", 32'(rise_q.size() > 0), 32'd1);
    axi_write(8'h10, 32'd20, 4'hF);
    read_chk("period_shadow", 8'h10, 32'd20);
    for (int i = 0; i < 80 && rise_q.size() < 3; i++) @(negedge clk);
    chk("rise_count", 32'(rise_q.size() >= 3), 32'd1);
    if (rise_q.size() >= 3) begin
      chk("interval_old", 32'(rise_q[1] - rise_q[0]), 32'd10);
      chk("interval_new", 32'(rise_q[2] - rise_q[1]), 32'd20);
    end

    // Reset while the pulse is high.
    for (int i = 0; i < 40 && sync_o[0] !== 1'b1; i++) @(negedge clk);
    chk("pulse_before_rst", 32'(sync_o[0]), 32'd1);
    do_reset();
    read_chk("post_rst_ctrl", 8'h00, 32'd0);
    read_chk("post_rst_period", 8'h10, 32'd0);

    // Two aligned channels with complementary windows.
    axi_write(8'h10, 32'd8, 4'hF);
    axi_write(8'h14, 32'd4, 4'hF);
    axi_write(8'h20, 32'd8, 4'hF);
    axi_write(8'h24, 32'd4, 4'hF);
    axi_write(8'h28, 32'd4, 4'hF);
    axi_write(8'h00, 32'h301, 4'hF);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      exp0 = ((k - 1) % 8) < 4;
      chk($sformatf("compl[%0d]", k), 32'(sync_o), {30'd0, ~exp0, exp0});
    end
    axi_write(8'h00, 32'h0, 4'hF);
    read_chk("pcnt_ch0", 8'h1C, 32'd4);
    read_chk("pcnt_ch1", 8'h2C, 32'd3);
    axi_write(8'h2C, 32'd1, 4'hF);
    read_chk("pcnt_ch1_clr", 8'h2C, 32'd0);
    axi_write(8'h1C, 32'd0, 4'hF);
    read_chk("pcnt_ch0_keep", 8'h1C, 32'd4);

    // Window truncated at period end, then PERIOD=0 stops the channel.
    do_reset();
    axi_write(8'h10, 32'd10, 4'hF);
    axi_write(8'h14, 32'd12, 4'hF);
    axi_write(8'h18, 32'd5, 4'hF);
    axi_write(8'h00, 32'h101, 4'hF);
    expect_window("trunc", 25, 10, 5, 17, 0);
    read_chk("status_run", 8'h04, 32'd1);
    axi_write(8'h10, 32'd0, 4'hF);
    read_chk("status_p0", 8'h04, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("p0_sync[%0d]", k), 32'(sync_o), 32'd0);
    end

    // Byte strobes, read-only and unmapped addresses, resync self-clear.
    axi_write(8'h28, 32'h12345678, 4'hF);
    read_chk("offset_full", 8'h28, 32'h12345678);
    axi_write(8'h28, 32'h00AB0000, 4'b0100);
    read_chk("offset_strb", 8'h28, 32'h12AB5678);
    axi_write(8'h04, 32'hFFFFFFFF, 4'hF);
    read_chk("status_ro", 8'h04, 32'd0);
    axi_write(8'h0C, 32'hDEADBEEF, 4'hF);
    read_chk("unmapped_0c", 8'h0C, 32'd0);
    read_chk("unmapped_50", 8'h50, 32'd0);
    axi_write(8'h00, 32'h103, 4'hF);
    read_chk("resync_clear", 8'h00, 32'h101);

`ifdef SPG_EXT_TRIG_EN
    // Armed channels wait for the external trigger, then start at count 0.
    axi_write(8'h00, 32'h0, 4'hF);
    axi_write(8'h10, 32'd10, 4'hF);
    axi_write(8'h14, 32'd3, 4'hF);
    axi_write(8'h18, 32'd2, 4'hF);
    axi_write(8'h00, 32'h105, 4'hF);
    highs = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (sync_o !== '0) highs++;
    end
    chk("armed_quiet", 32'(highs), 32'd0);
    read_chk("status_armed", 8'h04, 32'h80000001);
    @(negedge clk); ext_trig = 1'b1;
    @(posedge clk); #1 ext_trig = 1'b0;
    @(negedge clk);
    expect_window("trig", 25, 10, 2, 5, 0);
    read_chk("status_disarmed", 8'h04, 32'h00000001);
`else
    highs = 0;
    exp0 = ext_trig;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
